rv32r_exec_sequencer: RTL and testbench

- Multi-cycle control sequencer for the R-type RV32 datapath.
- Owns the PC and steps each instruction through fetch, decode, register read, ALU, writeback and PC update, using req/ready handshakes to the fetch unit, the decoder, the register file and the ALU.
- Detects instructions the decoder never resolves (non-R-type), flushes the decoder and skips them.
- Keeps retired and illegal instruction counters.

---
 rtl/rv32r_pkg.sv | 37 +++
 rtl/rv32r_dec_watchdog.sv | 31 +++
 rtl/rv32r_exec_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_rv32r_exec_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32r_pkg.sv
// Shared definitions for the R-type RV32 execution sequencer and its helpers.
package rv32r_pkg;

  // Sequencer states, one per step of an instruction's life.
  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecReq,
    StDecWait,
    StRead,
    StExec,
    StWb,
    StTrap,
    StNext
  } seq_state_e;

  // ALU opcodes as produced by the decoder.
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  // ALU unit selects.
  localparam logic [1:0] SelArith    = 2'd0;
  localparam logic [1:0] SelLogic    = 2'd1;
  localparam logic [1:0] SelShiftCmp = 2'd2;

  // Major opcode of every R-type instruction.
  localparam logic [6:0] OpcRtype = 7'b0110011;

endpackage

// File: rtl/rv32r_dec_watchdog.sv
// Decoder watchdog: a clearable, enabled up-counter that flags the last allowed
// wait cycle. It saturates there so a stuck enable can never wrap it back to zero.
module rv32r_dec_watchdog #(
  parameter int unsigned Timeout = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned CntW = (Timeout > 2) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q;

  // Count wait cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LastCnt)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout_o = (cnt_q == LastCnt);

endmodule

// File: rtl/rv32r_exec_sequencer.sv
// Multi-cycle control sequencer for the R-type RV32 datapath. Owns the PC and walks
// each instruction through fetch, decode, register read, ALU and writeback. Words the
// decoder never resolves are trapped, the decoder is flushed and the word is skipped.
// Every output is a flop, so each strobe is set on the edge that enters its state.
module rv32r_exec_sequencer
  import rv32r_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     DEC_TIMEOUT = 16,  // must be at least 8
  parameter int unsigned     CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  output logic             busy,
  output logic             cs_fetch,
  output logic [XLEN-1:0]  fetch_addr,
  input  logic             rdy_fetch,
  input  logic [31:0]      instr_in,
  output logic             cs_decoder,
  output logic [31:0]      dec_instr,
  input  logic             dec_valid,
  input  logic [3:0]       dec_op,
  input  logic [1:0]       dec_sel,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  output logic             dec_flush,
  output logic             rf_re,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic             cs_alu,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_sel,
  input  logic             rdy_alu,
  output logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             irq_illegal
);

  seq_state_e state_q;
  logic [3:0] op_q;
  logic [1:0] sel_q;
  logic [4:0] rd_q;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_timeout;

  // The watchdog is cleared while the decode strobe is out and runs only while waiting.
  always_comb begin
    wd_clr = (state_q == StDecReq);
    wd_en  = (state_q == StDecWait);
  end

  rv32r_dec_watchdog #(
    .Timeout (DEC_TIMEOUT)
  ) u_dec_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .timeout_o (wd_timeout)
  );

  assign fetch_addr = pc;

  // Sequencer FSM: next state, latched fields, counters and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc          <= RESET_PC;
      busy        <= 1'b0;
      cs_fetch    <= 1'b0;
      cs_decoder  <= 1'b0;
      dec_instr   <= '0;
      dec_flush   <= 1'b0;
      rf_re       <= 1'b0;
      rf_raddr1   <= '0;
      rf_raddr2   <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      cs_alu      <= 1'b0;
      alu_op      <= '0;
      alu_sel     <= '0;
      retired_cnt <= '0;
      illegal_cnt <= '0;
      irq_illegal <= 1'b0;
      op_q        <= '0;
      sel_q       <= '0;
      rd_q        <= '0;
    end else begin
      // Strobes default low; the entering transition raises the one it needs.
      cs_fetch    <= 1'b0;
      cs_decoder  <= 1'b0;
      dec_flush   <= 1'b0;
      rf_re       <= 1'b0;
      rf_we       <= 1'b0;
      cs_alu      <= 1'b0;
      irq_illegal <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StFetch;
            busy     <= 1'b1;
            cs_fetch <= 1'b1;
          end
        end
        StFetch: begin
          if (rdy_fetch) begin
            dec_instr  <= instr_in;
            state_q    <= StDecReq;
            cs_decoder <= 1'b1;
          end else begin
            cs_fetch <= 1'b1;
          end
        end
        StDecReq: begin
          state_q <= StDecWait;
        end
        StDecWait: begin
          // A valid result on the timeout cycle still counts as decoded.
          if (dec_valid) begin
            op_q      <= dec_op;
            sel_q     <= dec_sel;
            rd_q      <= dec_rd;
            rf_raddr1 <= dec_rs1;
            rf_raddr2 <= dec_rs2;
            rf_re     <= 1'b1;
            state_q   <= StRead;
          end else if (wd_timeout) begin
            dec_flush   <= 1'b1;
            irq_illegal <= 1'b1;
            state_q     <= StTrap;
          end
        end
        StRead: begin
          alu_op  <= op_q;
          alu_sel <= sel_q;
          cs_alu  <= 1'b1;
          state_q <= StExec;
        end
        StExec: begin
          if (rdy_alu) begin
            rf_waddr <= rd_q;
            rf_we    <= (rd_q != 5'd0);  // x0 is never written
            state_q  <= StWb;
          end else begin
            cs_alu <= 1'b1;
          end
        end
        StWb: begin
          if (retired_cnt != '1) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
          end
          state_q <= StNext;
        end
        StTrap: begin
          if (illegal_cnt != '1) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
          end
          state_q <= StNext;
        end
        StNext: begin
          pc <= pc + XLEN'(4);
          if (halt_req) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cs_fetch <= 1'b1;
            state_q  <= StFetch;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32r_exec_sequencer.sv
// Directed bench for rv32r_exec_sequencer with a small instruction memory and a
// behavioural decoder that answers R-type words three cycles after the strobe.
module tb_rv32r_exec_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        busy;
  logic        cs_fetch;
  logic [31:0] fetch_addr;
  logic        rdy_fetch;
  logic [31:0] instr_in;
  logic        cs_decoder;
  logic [31:0] dec_instr;
  logic        dec_valid;
  logic [3:0]  dec_op;
  logic [1:0]  dec_sel;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_flush;
  logic        rf_re;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        cs_alu;
  logic [3:0]  alu_op;
  logic [1:0]  alu_sel;
  logic        rdy_alu;
  logic [31:0] pc;
  logic [15:0] retired_cnt;
  logic [15:0] illegal_cnt;
  logic        irq_illegal;

  rv32r_exec_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .busy        (busy),
    .cs_fetch    (cs_fetch),
    .fetch_addr  (fetch_addr),
    .rdy_fetch   (rdy_fetch),
    .instr_in    (instr_in),
    .cs_decoder  (cs_decoder),
    .dec_instr   (dec_instr),
    .dec_valid   (dec_valid),
    .dec_op      (dec_op),
    .dec_sel     (dec_sel),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .dec_flush   (dec_flush),
    .rf_re       (rf_re),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .cs_alu      (cs_alu),
    .alu_op      (alu_op),
    .alu_sel     (alu_sel),
    .rdy_alu     (rdy_alu),
    .pc          (pc),
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt),
    .irq_illegal (irq_illegal)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [8];

  // Activity log written only by the monitor loop.
  int         cyc = 0;
  int         we_cnt = 0;
  int         re_cnt = 0;
  int         flush_cnt = 0;
  int         irq_cnt = 0;
  int         dec_cyc = 0;
  int         flush_gap = 0;
  int         alu_n = 0;
  logic       prev_alu = 1'b0;
  logic [4:0] last_waddr = '0;
  logic [4:0] last_ra1 = '0;
  logic [4:0] last_ra2 = '0;
  logic [3:0] alu_op_log [16];
  logic [1:0] alu_sel_log [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    rdy_fetch = 1'b1;
    rdy_alu = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_alu(input string tag);
    int n = 0;
    while (cs_alu !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, {31'd0, cs_alu}, 32'd1);
  endtask

  // Instruction memory and decoder model, driven away from the active edge.
  initial begin
    int  lat;
    bit  pend;
    lat = 0;
    pend = 1'b0;
    instr_in = '0;
    dec_valid = 1'b0;
    dec_op = '0;
    dec_sel = '0;
    dec_rs1 = '0;
    dec_rs2 = '0;
    dec_rd = '0;
    forever begin
      @(negedge clk);
      instr_in = mem[fetch_addr[4:2]];
      dec_valid = 1'b0;
      if (rst || dec_flush) begin
        pend = 1'b0;
      end else if (cs_decoder) begin
        pend = (dec_instr[6:0] == 7'b0110011);
        lat = 3;
      end else if (pend) begin
        if (lat == 0) begin
          dec_valid = 1'b1;
          dec_rs1 = dec_instr[19:15];
          dec_rs2 = dec_instr[24:20];
          dec_rd = dec_instr[11:7];
          case (dec_instr[14:12])
            3'b000: begin dec_op = dec_instr[30] ? 4'd1 : 4'd0; dec_sel = 2'd0; end
            3'b100: begin dec_op = 4'd5; dec_sel = 2'd1; end
            default: begin dec_op = 4'd0; dec_sel = 2'd0; end
          endcase
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  // Monitor: logs strobes once per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rf_we === 1'b1) begin we_cnt++; last_waddr = rf_waddr; end
      if (rf_re === 1'b1) begin re_cnt++; last_ra1 = rf_raddr1; last_ra2 = rf_raddr2; end
      if (cs_alu === 1'b1 && !prev_alu && alu_n < 16) begin
        alu_op_log[alu_n] = alu_op;
        alu_sel_log[alu_n] = alu_sel;
        alu_n++;
      end
      prev_alu = (cs_alu === 1'b1);
      if (cs_decoder === 1'b1) dec_cyc = cyc;
      if (dec_flush === 1'b1) begin flush_cnt++; flush_gap = cyc - dec_cyc; end
      if (irq_illegal === 1'b1) irq_cnt++;
    end
  end

  initial begin
    int we0, re0, alu0, fl0, irq0, n;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0000_0013;

    // Reset values.
    do_reset();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_strobes", {25'd0, cs_fetch, cs_decoder, dec_flush, rf_re, rf_we, cs_alu,
          irq_illegal}, 32'd0);
    check("rst_retired", {16'd0, retired_cnt}, 32'd0);
    check("rst_illegal", {16'd0, illegal_cnt}, 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);

    // Single add x1,x2,x3.
    mem[0] = 32'h0031_00B3;
    we0 = we_cnt; alu0 = alu_n;
    halt_req = 1'b1;
    pulse_start();
    check("t1_busy_on", {31'd0, busy}, 32'd1);
    check("t1_fetch", {31'd0, cs_fetch}, 32'd1);
    wait_idle("t1_idle");
    check("t1_ra1", {27'd0, last_ra1}, 32'd2);
    check("t1_ra2", {27'd0, last_ra2}, 32'd3);
    check("t1_aluop", {28'd0, alu_op_log[alu0]}, 32'd0);
    check("t1_we_cnt", we_cnt - we0, 32'd1);
    check("t1_waddr", {27'd0, last_waddr}, 32'd1);
    check("t1_pc", pc, 32'd4);
    check("t1_retired", {16'd0, retired_cnt}, 32'd1);

    // add / sub / xor back-to-back.
    do_reset();
    mem[0] = 32'h0031_00B3;
    mem[1] = 32'h4031_00B3;
    mem[2] = 32'h0031_C0B3;
    we0 = we_cnt; alu0 = alu_n;
    pulse_start();
    n = 0;
    while (alu_n - alu0 < 3 && n < 300) begin tick(); n++; end
    halt_req = 1'b1;
    wait_idle("t2_idle");
    check("t2_op0", {28'd0, alu_op_log[alu0]}, 32'd0);
    check("t2_op1", {28'd0, alu_op_log[alu0+1]}, 32'd1);
    check("t2_op2", {28'd0, alu_op_log[alu0+2]}, 32'd5);
    check("t2_sel0", {30'd0, alu_sel_log[alu0]}, 32'd0);
    check("t2_sel1", {30'd0, alu_sel_log[alu0+1]}, 32'd0);
    check("t2_sel2", {30'd0, alu_sel_log[alu0+2]}, 32'd1);
    check("t2_pc", pc, 32'd12);
    check("t2_retired", {16'd0, retired_cnt}, 32'd3);
    check("t2_we_cnt", we_cnt - we0, 32'd3);

    // Illegal addi, then a normal add.
    do_reset();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0031_00B3;
    we0 = we_cnt; re0 = re_cnt; fl0 = flush_cnt; irq0 = irq_cnt;
    pulse_start();
    n = 0;
    while (re_cnt == re0 && n < 300) begin tick(); n++; end
    halt_req = 1'b1;
    wait_idle("t3_idle");
    check("t3_flush_cnt", flush_cnt - fl0, 32'd1);
    check("t3_irq_cycles", irq_cnt - irq0, 32'd1);
    check("t3_flush_gap", flush_gap, 32'd17);
    check("t3_illegal", {16'd0, illegal_cnt}, 32'd1);
    check("t3_retired", {16'd0, retired_cnt}, 32'd1);
    check("t3_re_cnt", re_cnt - re0, 32'd1);
    check("t3_we_cnt", we_cnt - we0, 32'd1);
    check("t3_pc", pc, 32'd8);

    // Write to x0 is suppressed but still retires.
    do_reset();
    mem[0] = 32'h0031_0033;
    we0 = we_cnt;
    halt_req = 1'b1;
    pulse_start();
    wait_idle("t4_idle");
    check("t4_we_cnt", we_cnt - we0, 32'd0);
    check("t4_retired", {16'd0, retired_cnt}, 32'd1);
    check("t4_pc", pc, 32'd4);

    // Fetch and ALU back-pressure.
    do_reset();
    mem[0] = 32'h0031_00B3;
    we0 = we_cnt;
    rdy_fetch = 1'b0;
    rdy_alu = 1'b0;
    halt_req = 1'b1;
    pulse_start();
    repeat (5) tick();
    check("t5_fetch_held", {31'd0, cs_fetch}, 32'd1);
    check("t5_fetch_addr", fetch_addr, 32'd0);
    rdy_fetch = 1'b1;
    wait_alu("t5_alu_seen");
    repeat (3) tick();
    check("t5_alu_held", {31'd0, cs_alu}, 32'd1);
    check("t5_alu_fields", {26'd0, alu_op, alu_sel}, 32'd0);
    check("t5_no_we_yet", {31'd0, rf_we}, 32'd0);
    rdy_alu = 1'b1;
    wait_idle("t5_idle");
    check("t5_we_cnt", we_cnt - we0, 32'd1);
    check("t5_waddr", {27'd0, last_waddr}, 32'd1);

    // halt_req raised during EXEC lets the instruction finish.
    do_reset();
    mem[0] = 32'h0031_00B3;
    mem[1] = 32'h0031_C0B3;
    alu0 = alu_n;
    rdy_alu = 1'b0;
    pulse_start();
    wait_alu("t6_alu_seen");
    halt_req = 1'b1;
    rdy_alu = 1'b1;
    wait_idle("t6_idle");
    check("t6_pc", pc, 32'd4);
    check("t6_retired", {16'd0, retired_cnt}, 32'd1);
    check("t6_alu_cnt", alu_n - alu0, 32'd1);

    // Reset while stalled in EXEC of the second instruction.
    do_reset();
    mem[0] = 32'h0031_00B3;
    mem[1] = 32'h0031_C0B3;
    pulse_start();
    n = 0;
    while (retired_cnt !== 16'd1 && n < 100) begin tick(); n++; end
    check("t7_first_retired", {16'd0, retired_cnt}, 32'd1);
    rdy_alu = 1'b0;
    tick();
    wait_alu("t7_alu_seen");
    rst = 1'b1;
    tick();
    check("t7_pc", pc, 32'd0);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_strobes", {25'd0, cs_fetch, cs_decoder, dec_flush, rf_re, rf_we, cs_alu,
          irq_illegal}, 32'd0);
    check("t7_retired", {16'd0, retired_cnt}, 32'd0);
    check("t7_fields", {11'd0, rf_raddr1, rf_raddr2, rf_waddr, alu_op, alu_sel}, 32'd0);
    check("t7_dec_instr", dec_instr, 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
